// File: rtl/noc_pkg.sv
// Shared types and packet-format constants for the NoC port buffer.
package noc_pkg;

  typedef enum logic [2:0] {
    RD_RESP = 3'b011,
    WR_RESP = 3'b100,
    MSG     = 3'b101
  } pkt_type_e;

  typedef enum logic [2:0] {
    ING_IDLE,
    ING_HDR_FIELDS,
    ING_LEN,
    ING_DATA,
    ING_DISCARD
  } ingress_state_e;

  typedef enum logic [1:0] {
    EG_IDLE,
    EG_HEAD,
    EG_BODY,
    EG_LAST
  } egress_state_e;

  localparam int unsigned WR_RESP_FLITS     = 4;
  localparam int unsigned MSG_FLITS         = 5;
  localparam int unsigned RD_RESP_HDR_FLITS = 4;
  localparam int unsigned LEN_OFFSET        = 3;

  function automatic logic is_valid_type(input logic [2:0] t);
    return (t == RD_RESP) || (t == WR_RESP) || (t == MSG);
  endfunction

  // Flits still to come after the header; RD_RESP counts only dst/src here,
  // the len flit reloads the counter.
  function automatic logic [8:0] hdr_rem(input logic [2:0] t);
    if (t == RD_RESP)      return 9'(RD_RESP_HDR_FLITS - 2);
    else if (t == WR_RESP) return 9'(WR_RESP_FLITS - 1);
    else                   return 9'(MSG_FLITS - 1);
  endfunction

  function automatic logic [8:0] pkt_flits(input logic [2:0] t, input logic [7:0] len);
    if (t == RD_RESP)      return 9'(RD_RESP_HDR_FLITS) + {1'b0, len};
    else if (t == WR_RESP) return 9'(WR_RESP_FLITS);
    else                   return 9'(MSG_FLITS);
  endfunction

endpackage

// File: rtl/noc_port_buffer_if.sv
// Ingress flit stream plus router req/grant/lock egress stream.
interface noc_port_buffer_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req;
  logic          grant;
  logic          lock;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          cntl;

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, lock, out_valid, out_data, cntl
  );

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, lock, out_valid, out_data, cntl
  );
endinterface

// File: rtl/noc_commit_fifo.sv
// FIFO with a speculative write pointer that is either committed (packet
// becomes readable) or rewound to the last commit point.
module noc_commit_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          commit,
  input  logic          abort,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] peek_data,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   cmt_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   used;
  logic [AW-1:0] peek_idx;

  assign used      = wr_ptr - rd_ptr;
  assign full      = used[AW];
  assign empty     = (cmt_ptr == rd_ptr);
  assign peek_idx  = rd_ptr[AW-1:0] + AW'(LEN_OFFSET);
  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign peek_data = mem[peek_idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (abort)      wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      // Commit includes the flit written in the same cycle.
      if (commit) cmt_ptr <= wr_ptr + (AW+1)'(wr_en);
      if (rd_en)  rd_ptr  <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/noc_port_buffer.sv
// Store-and-forward NoC ingress buffer streaming whole packets to a switch
// arbiter under req/grant/lock.
module noc_port_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PKT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_port_buffer_if.slave     bus,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic                 drop_pulse,
  output logic                 bad_hdr_pulse
);
  ingress_state_e in_state, disc_phase, cnt_phase, step_phase;
  egress_state_e  eg_state;

  logic [8:0]    in_rem, step_rem, eg_rem;
  logic          is_rd, step_last;
  logic          fifo_full, fifo_empty, full_eff, sat;
  logic          in_ready, accept, mid, abort, hdr_ok, wr_en, commit;
  logic          req, take, rd_en, eg_done;
  logic          lock, out_valid, cntl;
  logic [DW-1:0] out_data, rd_data, peek_data;
  logic [2:0]    in_type;
  logic [7:0]    in_len;

  noc_commit_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (bus.in_data),
    .commit    (commit),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .peek_data (peek_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_type = bus.in_data[2:0];
  assign in_len  = bus.in_data[7:0];

  assign req     = (pkt_count != '0) && !lock;
  assign take    = (eg_state == EG_IDLE) && req && grant_ok();
  assign rd_en   = take || (eg_state == EG_HEAD) || (eg_state == EG_BODY);
  assign eg_done = (eg_state == EG_LAST);

  function automatic logic grant_ok();
    return bus.grant && !fifo_empty;
  endfunction

  always_comb begin
    full_eff = fifo_full && !rd_en;
    sat      = &pkt_count;
    in_ready = (in_state == ING_DISCARD) || (!full_eff && !sat);
    accept   = bus.in_valid && in_ready;
    mid      = (in_state == ING_HDR_FIELDS) || (in_state == ING_LEN) || (in_state == ING_DATA);
    abort    = mid && full_eff;
    hdr_ok   = (in_state == ING_IDLE) && accept && (bus.in_data != '0) && is_valid_type(in_type);

    // Packet-length tracking is shared between normal receive and DISCARD so
    // a dropped packet is consumed exactly to its end.
    cnt_phase  = (in_state == ING_DISCARD) ? disc_phase : in_state;
    step_phase = cnt_phase;
    step_rem   = in_rem;
    step_last  = 1'b0;
    case (cnt_phase)
      ING_HDR_FIELDS: begin
        if (in_rem == 9'd1) begin
          if (is_rd) step_phase = ING_LEN;
          else       step_last  = 1'b1;
        end else begin
          step_rem = in_rem - 9'd1;
        end
      end
      ING_LEN: begin
        if (in_len == 8'd0) begin
          step_last = 1'b1;
        end else begin
          step_phase = ING_DATA;
          step_rem   = {1'b0, in_len};
        end
      end
      ING_DATA: begin
        if (in_rem == 9'd1) step_last = 1'b1;
        else                step_rem  = in_rem - 9'd1;
      end
      default: ;
    endcase

    wr_en  = hdr_ok || (mid && accept);
    commit = mid && accept && step_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state      <= ING_IDLE;
      disc_phase    <= ING_IDLE;
      in_rem        <= '0;
      is_rd         <= 1'b0;
      drop_pulse    <= 1'b0;
      bad_hdr_pulse <= 1'b0;
    end else begin
      drop_pulse    <= 1'b0;
      bad_hdr_pulse <= 1'b0;
      case (in_state)
        ING_IDLE: begin
          if (accept && (bus.in_data != '0)) begin
            if (is_valid_type(in_type)) begin
              in_state <= ING_HDR_FIELDS;
              in_rem   <= hdr_rem(in_type);
              is_rd    <= (in_type == RD_RESP);
            end else begin
              bad_hdr_pulse <= 1'b1;
            end
          end
        end
        ING_HDR_FIELDS, ING_LEN, ING_DATA: begin
          if (abort) begin
            in_state   <= ING_DISCARD;
            disc_phase <= in_state;
            drop_pulse <= 1'b1;
          end else if (accept) begin
            in_rem   <= step_rem;
            in_state <= step_last ? ING_IDLE : step_phase;
          end
        end
        ING_DISCARD: begin
          if (accept) begin
            in_rem     <= step_rem;
            disc_phase <= step_phase;
            if (step_last) in_state <= ING_IDLE;
          end
        end
        default: in_state <= ING_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eg_state  <= EG_IDLE;
      eg_rem    <= '0;
      lock      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cntl      <= 1'b1;
    end else begin
      case (eg_state)
        EG_IDLE: begin
          if (take) begin
            eg_state  <= EG_HEAD;
            eg_rem    <= pkt_flits(rd_data[2:0], peek_data[7:0]) - 9'd1;
            lock      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= rd_data;
            cntl      <= 1'b1;
          end
        end
        EG_HEAD, EG_BODY: begin
          eg_state <= (eg_rem == 9'd1) ? EG_LAST : EG_BODY;
          eg_rem   <= eg_rem - 9'd1;
          out_data <= rd_data;
          cntl     <= 1'b0;
        end
        EG_LAST: begin
          eg_state  <= EG_IDLE;
          lock      <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
          cntl      <= 1'b1;
        end
        default: eg_state <= EG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (commit && !eg_done) begin
      if (!sat) pkt_count <= pkt_count + 1'b1;
    end else if (eg_done && !commit) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.req       = req;
  assign bus.lock      = lock;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.cntl      = cntl;
endmodule

// File: tb/tb_noc_port_buffer.sv
// Bench for noc_port_buffer: queue-based packet model compared every cycle,
// plus directed packets with literal expected streams.
module tb_noc_port_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int MAXC  = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  noc_port_buffer_if #(.DW(DW)) bus();
  logic [CW-1:0] pkt_count;
  logic          drop_pulse;
  logic          bad_hdr_pulse;

  noc_port_buffer #(.DW(DW), .DEPTH(DEPTH), .PKT_CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .pkt_count     (pkt_count),
    .drop_pulse    (drop_pulse),
    .bad_hdr_pulse (bad_hdr_pulse)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: committed flits, packet lengths, partial packet, egress progress.
  int m_cq[$];
  int m_lens[$];
  int m_part[$];
  int m_seen, m_total, m_type, m_count, m_erem, m_od;
  bit m_dropping, m_lock, m_ov, m_cntl, m_drop, m_bad;
  bit started = 0;

  function automatic bit m_reading();
    return (!m_lock && m_count > 0 && bus.grant) || (m_lock && m_erem > 0);
  endfunction

  function automatic bit m_in_ready();
    bit full;
    if (m_dropping) return 1'b1;
    full = (m_cq.size() + m_part.size()) == DEPTH;
    return !(full && !m_reading()) && (m_count < MAXC);
  endfunction

  always @(posedge clk) begin : model
    bit rd, acc, full_eff, inc, dec;
    int d, n;
    if (reset) begin
      started = 1;
      m_cq.delete(); m_lens.delete(); m_part.delete();
      m_seen = 0; m_total = 0; m_type = 0; m_count = 0; m_erem = 0;
      m_dropping = 0; m_lock = 0; m_ov = 0; m_od = 0; m_cntl = 1;
      m_drop = 0; m_bad = 0;
    end else if (started) begin
      rd = m_reading();
      acc = bus.in_valid && m_in_ready();
      full_eff = ((m_cq.size() + m_part.size()) == DEPTH) && !rd;
      d = int'(bus.in_data);
      m_drop = 0; m_bad = 0; inc = 0; dec = 0;
      if (m_dropping) begin
        if (acc) begin
          m_seen++;
          if (m_seen == 4 && m_type == 3) m_total = 4 + (d & 255);
          if (m_seen == m_total) begin m_dropping = 0; m_seen = 0; end
        end
      end else if (m_seen == 0) begin
        if (acc && d != 0) begin
          if ((d & 7) >= 3 && (d & 7) <= 5) begin
            m_part.push_back(d);
            m_seen = 1;
            m_type = d & 7;
            m_total = (m_type == 5) ? 5 : 4;
          end else begin
            m_bad = 1;
          end
        end
      end else if (full_eff) begin
        m_part.delete();
        m_dropping = 1;
        m_drop = 1;
      end else if (acc) begin
        m_part.push_back(d);
        m_seen++;
        if (m_seen == 4 && m_type == 3) m_total = 4 + (d & 255);
        if (m_seen == m_total) begin
          foreach (m_part[i]) m_cq.push_back(m_part[i]);
          m_lens.push_back(m_total);
          m_part.delete();
          m_seen = 0;
          inc = 1;
        end
      end
      if (!m_lock) begin
        if (m_count > 0 && bus.grant) begin
          n = m_lens.pop_front();
          m_od = m_cq.pop_front();
          m_ov = 1; m_cntl = 1; m_lock = 1; m_erem = n - 1;
        end
      end else if (m_erem > 0) begin
        m_od = m_cq.pop_front();
        m_cntl = 0;
        m_erem--;
      end else begin
        m_ov = 0; m_od = 0; m_cntl = 1; m_lock = 0; dec = 1;
      end
      if (inc && !dec && m_count < MAXC) m_count++;
      else if (dec && !inc) m_count--;
    end
  end

  // Recorded DUT activity for the directed literal checks.
  int out_q[$];
  int cntl_q[$];
  int idx_q[$];
  int cyc = 0;
  int drop_cnt, bad_cnt, peak;
  bit req_seen;

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", bus.in_ready, m_in_ready());
      chk("req", bus.req, (m_count > 0) && !m_lock);
      chk("lock", bus.lock, m_lock);
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_od);
      chk("cntl", bus.cntl, m_cntl);
      chk("pkt_count", pkt_count, m_count);
      chk("drop_pulse", drop_pulse, m_drop);
      chk("bad_hdr_pulse", bad_hdr_pulse, m_bad);
      if (bus.out_valid) begin
        out_q.push_back(int'(bus.out_data));
        cntl_q.push_back(int'(bus.cntl));
        idx_q.push_back(cyc);
      end
      if (drop_pulse) drop_cnt++;
      if (bad_hdr_pulse) bad_cnt++;
      if (bus.req) req_seen = 1;
      if (int'(pkt_count) > peak) peak = int'(pkt_count);
      cyc++;
    end
  end

  int exp_d[$];
  int exp_c[$];

  task automatic clear_rec();
    out_q.delete(); cntl_q.delete(); idx_q.delete();
    exp_d.delete(); exp_c.delete();
    drop_cnt = 0; bad_cnt = 0; peak = 0; req_seen = 0;
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, out_q.size(), exp_d.size());
    foreach (exp_d[i]) begin
      if (i < out_q.size()) begin
        chk({name, "_data"}, out_q[i], exp_d[i]);
        chk({name, "_cntl"}, cntl_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic send(input logic [7:0] f);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_grant();
    bus.grant = 1'b1;
    @(posedge clk); #1;
    bus.grant = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.grant    = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_req", bus.req, 0);
    chk("rst_lock", bus.lock, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cntl", bus.cntl, 1);
    chk("rst_pkt_count", pkt_count, 0);
    @(posedge clk); #1;

    // WR_RESP
    clear_rec();
    send(8'h04); send(8'h11); send(8'h22);
    chk("wr_req_before_last", bus.req, 0);
    send(8'h33);
    chk("wr_req_after_last", bus.req, 1);
    chk("wr_count_1", pkt_count, 1);
    pulse_grant();
    idle(6);
    exp_d = '{8'h04, 8'h11, 8'h22, 8'h33};
    exp_c = '{1, 0, 0, 0};
    check_stream("wr_resp");
    chk("wr_count_0", pkt_count, 0);
    chk("wr_lock_low", bus.lock, 0);

    // RD_RESP len=2
    clear_rec();
    send(8'h03); send(8'h0A); send(8'h0B); send(8'h02); send(8'hD0); send(8'hD1);
    pulse_grant();
    idle(8);
    exp_d = '{8'h03, 8'h0A, 8'h0B, 8'h02, 8'hD0, 8'hD1};
    exp_c = '{1, 0, 0, 0, 0, 0};
    check_stream("rd_resp");

    // Overflow: RD_RESP len=10 needs 14 entries in an 8-deep buffer
    clear_rec();
    send(8'h03); send(8'h01); send(8'h02); send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i));
    idle(3);
    chk("ovf_drop_once", drop_cnt, 1);
    chk("ovf_no_req", req_seen, 0);
    chk("ovf_count", pkt_count, 0);
    clear_rec();
    send(8'h05); send(8'h01); send(8'h02); send(8'hA0); send(8'hB0);
    pulse_grant();
    idle(7);
    exp_d = '{8'h05, 8'h01, 8'h02, 8'hA0, 8'hB0};
    exp_c = '{1, 0, 0, 0, 0};
    check_stream("post_ovf_msg");

    // Invalid and null headers
    clear_rec();
    send(8'h07);
    idle(2);
    chk("bad_hdr_once", bad_cnt, 1);
    send(8'h00);
    idle(2);
    chk("null_hdr_silent", bad_cnt, 1);
    chk("bad_no_req", req_seen, 0);
    chk("bad_count", pkt_count, 0);
    chk("bad_no_drop", drop_cnt, 0);

    // Two MSGs back-to-back, grant held high
    clear_rec();
    bus.grant = 1'b1;
    send(8'h05); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h25); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    idle(10);
    bus.grant = 1'b0;
    idle(2);
    chk("two_msg_peak", peak, 2);
    exp_d = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h25, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    exp_c = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    check_stream("two_msg");
    if (idx_q.size() == 10) chk("two_msg_gap", idx_q[5] - idx_q[4], 2);
    else chk("two_msg_count", idx_q.size(), 10);

    // Reset mid-egress
    clear_rec();
    send(8'h03); send(8'h0A); send(8'h0B); send(8'h02); send(8'hD0); send(8'hD1);
    pulse_grant();
    idle(2);
    chk("mid_egress_lock", bus.lock, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_in_ready", bus.in_ready, 1);
    chk("rst2_req", bus.req, 0);
    chk("rst2_lock", bus.lock, 0);
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_out_data", bus.out_data, 0);
    chk("rst2_cntl", bus.cntl, 1);
    chk("rst2_pkt_count", pkt_count, 0);
    idle(3);
    chk("rst2_req_stays_low", bus.req, 0);
    clear_rec();
    send(8'h04); send(8'h55); send(8'h66); send(8'h77);
    pulse_grant();
    idle(6);
    exp_d = '{8'h04, 8'h55, 8'h66, 8'h77};
    exp_c = '{1, 0, 0, 0};
    check_stream("post_rst_wr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/noc_port_buffer.md
Name: noc_port_buffer

Overview:
- Parametrised successor to the switch-port packet FIFO interface. It buffers inbound NoC packets (read response, write response, message) in store-and-forward fashion, then streams each complete packet to the router under a req/grant/lock handshake.
- New relative to the previous generation: parametrised width and depth, in_ready backpressure, whole-packet abort on overflow, header validation, and a count of buffered packets.
- Sits between a device/link ingress and one switch arbiter input.

Parameters:
- DW, 8, data/flit width in bits (>= 8; type field is bits [2:0], length field is the low 8 bits).
- DEPTH, 16, FIFO entries (power of 2, >= 8).
- PKT_CNT_W, 4, width of the buffered-packet counter (saturates at 2**PKT_CNT_W-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  inbound flit strobe
- in_data  in  DW  inbound flit
- in_ready  out  1  buffer can accept a flit this cycle
- req  out  1  at least one complete packet buffered
- grant  in  1  arbiter grant, sampled only while req=1 and lock=0
- lock  out  1  port owns the switch for the current packet
- out_valid  out  1  out_data carries a flit
- out_data  out  DW  outbound flit, 0 when not valid
- cntl  out  1  1 on header flit and when idle, 0 on body flits
- pkt_count  out  PKT_CNT_W  complete packets buffered
- drop_pulse  out  1  one-cycle pulse: packet aborted on overflow
- bad_hdr_pulse  out  1  one-cycle pulse: invalid header rejected

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates on posedge clk only.
- Reset values: in_ready=1, req=0, lock=0, out_valid=0, out_data=0, cntl=1, pkt_count=0, both pulses 0, pointers 0, both FSMs IDLE.
- Packet format, flit 0 = header, type in bits [2:0]:
  - 3'b011 RD_RESP: hdr, dst, src, len, then len data flits; total 4+len.
  - 3'b100 WR_RESP: hdr, dst, src, status; total 4.
  - 3'b101 MSG: hdr, dst, src, addr, data; total 5.
- Ingress FSM states: IDLE, HDR_FIELDS, LEN, DATA, DISCARD.
  - A flit is accepted when in_valid=1 and in_ready=1. in_ready = !full, except in DISCARD, where in_ready=1 and flits are sunk.
  - IDLE: in_data==0 is ignored silently. A nonzero header with a type outside the three codes is not written and raises bad_hdr_pulse. A valid header is written to the FIFO.
  - A down-counter, loaded from the type (or from the len flit for RD_RESP), tracks remaining flits. After the last flit is accepted, the committed write pointer advances to the write pointer, pkt_count++, and the FSM returns to IDLE.
  - Overflow: full is reached mid-packet while flits remain. The write pointer rewinds to the committed pointer, drop_pulse fires, and the FSM enters DISCARD, consuming the remaining flits (counter still running) and writing none of them. It then returns to IDLE. An uncommitted packet is never visible to egress.
- Egress FSM states: IDLE, HEAD, BODY, LAST.
  - req = (pkt_count>0) && !lock.
  - grant sampled high in IDLE with req=1: lock=1 next cycle. On the cycle after the grant edge, out_valid=1, out_data=header, cntl=1 (one-cycle latency).
  - Following cycles emit one flit per cycle with cntl=0. No backpressure on egress. The length is parsed from the FIFO (byte 3 for RD_RESP).
  - After the last flit: out_valid=0, out_data=0, cntl=1, lock=0, pkt_count--, FSM to IDLE.
  - A new grant may be taken the cycle after lock falls, giving a one-cycle gap between packets.
- Simultaneous ingress commit and egress completion: pkt_count is unchanged. A read freeing an entry in the same cycle as the full-check counts as not full.
- pkt_count saturates at its maximum; in_ready is held 0 while it is saturated.
- Reset mid-packet on either side: all state cleared, partial packets lost, no pulses.
- Width rules: len is in_data[7:0], zero-extended. The RD_RESP len=0 packet is 4 flits. Counters are 9 bits.

Decomposition:
- noc_pkg: pkt_type_e (RD_RESP=3'b011, WR_RESP=3'b100, MSG=3'b101), ingress_state_e, egress_state_e, constants WR_RESP_FLITS=4, MSG_FLITS=5, RD_RESP_HDR_FLITS=4, LEN_OFFSET=3.
- Sub-module noc_commit_fifo: a DEPTH x DW FIFO with separate committed and speculative write pointers and commit/abort inputs. It reports full/empty, where empty is measured against the committed pointer.

Test Plan:
- WR_RESP 8'h04,8'h11,8'h22,8'h33, then grant: req rises after the 4th flit; out_data 04,11,22,33 on the 4 cycles after grant; cntl 1,0,0,0; lock falls after 33; pkt_count 1->0.
- RD_RESP 8'h03,8'h0A,8'h0B,8'h02,8'hD0,8'hD1: 6 flits out in order, cntl=1 only on 03.
- DEPTH=8, RD_RESP with len=10: drop_pulse once, the remaining 6 flits are sunk, req never rises, pkt_count=0. A following MSG 05,01,02,A0,B0 passes intact.
- Header 8'h07 -> bad_hdr_pulse, nothing stored. Header 8'h00 -> ignored, no pulse.
- Two MSGs back-to-back with grant held high: pkt_count reaches 2, the packets are separated by one idle cycle with cntl=1, and no flits interleave.
- reset asserted for 1 cycle mid-egress of a RD_RESP: next cycle all outputs at reset values, pkt_count=0, FIFO empty.
